cache_fill_ctrl: RTL and testbench

- Cache controller that drives the 2-way, 64-set metadata array and the companion data array of the L1 cache.
- On a request it compares tags, then updates LRU on a hit.
- On a miss it fetches the 8-word (16-byte) line from the pipelined main memory, fills the victim way, and writes the new tag, valid and LRU bits.
- It is the stage directly upstream of the metadata array: it generates the array's one-hot set enable, write enables and write data, and consumes its two read bytes.

---
 rtl/cache_fill_ctrl.sv | 150 +++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - 2-way L1 metadata/fill controller: tag compare, LRU update, 8-word line fill
module cache_fill_ctrl #(
    parameter int TAG_W = 6,
    parameter int IDX_W = 6,
    parameter int WORDS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req,
    input  logic [15:0]                   req_addr,
    output logic                          busy,
    output logic                          done,
    output logic                          hit,
    output logic [(2**IDX_W)-1:0]         meta_set_en,
    output logic [TAG_W+1:0]              meta_din,
    output logic                          meta_we0,
    output logic                          meta_we1,
    input  logic [TAG_W+1:0]              meta_dout0,
    input  logic [TAG_W+1:0]              meta_dout1,
    output logic                          mem_en,
    output logic [TAG_W+IDX_W+$clog2(WORDS):0] mem_addr,
    input  logic [15:0]                   mem_rdata,
    input  logic                          mem_valid,
    output logic                          data_we,
    output logic                          data_way,
    output logic [WORDS-1:0]              data_word_en,
    output logic [15:0]                   data_wdata
);
    localparam int SETS = 2**IDX_W;
    localparam int WB   = $clog2(WORDS);
    localparam logic [WB:0]   N_WORDS   = (WB+1)'(WORDS);
    localparam logic [WB-1:0] LAST_WORD = WB'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMP, S_LRU, S_FILL, S_MV, S_ML, S_DONE
    } state_t;

    state_t             state, state_nx;
    logic [TAG_W-1:0]   tag_q;
    logic [IDX_W-1:0]   idx_q;
    logic [TAG_W+1:0]   way0_q;
    logic               hitway_q;
    logic               victim_q;
    logic [WB:0]        issue_cnt;
    logic [WB:0]        recv_cnt;

    logic hit0, hit1, victim;

    // way-1 LRU bit carries no information; way-0 holds the set's LRU state
    logic unused_lru1;
    assign unused_lru1 = meta_dout1[TAG_W];

    assign hit0   = meta_dout0[TAG_W+1] && (meta_dout0[TAG_W-1:0] == tag_q);
    assign hit1   = meta_dout1[TAG_W+1] && (meta_dout1[TAG_W-1:0] == tag_q);
    assign victim = !meta_dout0[TAG_W+1] ? 1'b0 :
                    !meta_dout1[TAG_W+1] ? 1'b1 : !meta_dout0[TAG_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            tag_q     <= '0;
            idx_q     <= '0;
            way0_q    <= '0;
            hitway_q  <= 1'b0;
            victim_q  <= 1'b0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        tag_q <= req_addr[15:16-TAG_W];
                        idx_q <= req_addr[15-TAG_W:16-TAG_W-IDX_W];
                    end
                end
                S_CMP: begin
                    way0_q    <= meta_dout0;
                    hitway_q  <= !hit0;
                    victim_q  <= victim;
                    issue_cnt <= '0;
                    recv_cnt  <= '0;
                end
                S_FILL: begin
                    if (issue_cnt < N_WORDS) issue_cnt <= issue_cnt + 1'b1;
                    if (mem_valid)           recv_cnt  <= recv_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx     = state;
        busy         = (state != S_IDLE);
        done         = 1'b0;
        hit          = 1'b0;
        meta_set_en  = (state != S_IDLE) ? (SETS'(1) << idx_q) : '0;
        meta_din     = '0;
        meta_we0     = 1'b0;
        meta_we1     = 1'b0;
        mem_en       = 1'b0;
        mem_addr     = '0;
        data_we      = 1'b0;
        data_way     = 1'b0;
        data_word_en = '0;
        data_wdata   = '0;
        case (state)
            S_IDLE: if (req) state_nx = S_CMP;
            S_CMP:  state_nx = (hit0 || hit1) ? S_LRU : S_FILL;
            S_LRU: begin
                meta_we0 = 1'b1;
                meta_din = {way0_q[TAG_W+1], hitway_q, way0_q[TAG_W-1:0]};
                done     = 1'b1;
                hit      = 1'b1;
                state_nx = S_IDLE;
            end
            S_FILL: begin
                if (issue_cnt < N_WORDS) begin
                    mem_en   = 1'b1;
                    mem_addr = {tag_q, idx_q, issue_cnt[WB-1:0], 1'b0};
                end
                if (mem_valid) begin
                    data_we      = 1'b1;
                    data_way     = victim_q;
                    data_word_en = WORDS'(1) << recv_cnt[WB-1:0];
                    data_wdata   = mem_rdata;
                    if (recv_cnt[WB-1:0] == LAST_WORD) state_nx = S_MV;
                end
            end
            S_MV: begin
                meta_din = {1'b1, 1'b0, tag_q};
                meta_we0 = !victim_q;
                meta_we1 = victim_q;
                state_nx = victim_q ? S_ML : S_DONE;
            end
            // way1 just became MRU, so way0 is now the victim
            S_ML: begin
                meta_we0 = 1'b1;
                meta_din = {way0_q[TAG_W+1], 1'b1, way0_q[TAG_W-1:0]};
                state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - randomized self-checking bench for cache_fill_ctrl
module tb_cache_fill_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [15:0] req_addr = '0;
    logic        busy, done, hit;
    logic [63:0] meta_set_en;
    logic [7:0]  meta_din;
    logic        meta_we0, meta_we1;
    logic [7:0]  meta_dout0, meta_dout1;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;
    logic        data_we, data_way;
    logic [7:0]  data_word_en;
    logic [15:0] data_wdata;

    cache_fill_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr),
        .busy(busy), .done(done), .hit(hit),
        .meta_set_en(meta_set_en), .meta_din(meta_din),
        .meta_we0(meta_we0), .meta_we1(meta_we1),
        .meta_dout0(meta_dout0), .meta_dout1(meta_dout1),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .data_we(data_we), .data_way(data_way), .data_word_en(data_word_en), .data_wdata(data_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // metadata array environment: combinational read of the selected set
    logic [7:0] arr0 [64];
    logic [7:0] arr1 [64];

    function automatic int oh(input logic [63:0] v);
        for (int i = 0; i < 64; i++) if (v[i]) return i;
        return 0;
    endfunction

    always_comb begin
        meta_dout0 = 8'h00;
        meta_dout1 = 8'h00;
        if (|meta_set_en) begin
            if (!meta_we0) meta_dout0 = arr0[oh(meta_set_en)];
            if (!meta_we1) meta_dout1 = arr1[oh(meta_set_en)];
        end
    end

    always @(posedge clk) begin
        if (meta_we0) arr0[oh(meta_set_en)] <= meta_din;
        if (meta_we1) arr1[oh(meta_set_en)] <= meta_din;
    end

    // reference cache state per set
    bit       mv [2][64];
    bit [5:0] mt [2][64];
    bit       ml [64];

    typedef struct packed { int due; logic [15:0] data; } ret_t;
    ret_t        pend[$];
    logic [15:0] salt;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic [15:0] data_of(input logic [15:0] a);
        return (a * 16'h9E37) ^ salt;
    endfunction

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_ctl"}, 32'({busy, done, hit, meta_we0, meta_we1, mem_en, data_we, data_way}), 0);
        check_eq({tag, "_set_en"}, 32'(|meta_set_en), 0);
        check_eq({tag, "_bus"}, {meta_din, mem_addr, data_word_en}, 0);
        check_eq({tag, "_wdata"}, 32'(data_wdata), 0);
    endtask

    task automatic do_req(input logic [15:0] addr, input int lmin, input int lmax, input int abort_at);
        logic [5:0]  tag, idx;
        logic [2:0]  wv;
        bit          h0, h1, is_hit, vic, fin, hit_obs;
        logic [8:0]  exp_meta[$], obs_meta[$];
        logic [15:0] exp_addr[$], obs_addr[$];
        logic [24:0] exp_dw[$], obs_dw[$];
        int          ndone, done_c, last_dw, req_c, viol, last_due, lat, due;
        tag = addr[15:10];
        idx = addr[9:4];
        salt = 16'($urandom);
        vic = 1'b0; fin = 1'b0; hit_obs = 1'b0;
        ndone = 0; done_c = 0; last_dw = 0; viol = 0; last_due = 0;

        h0 = mv[0][idx] && mt[0][idx] == tag;
        h1 = !h0 && mv[1][idx] && mt[1][idx] == tag;
        is_hit = h0 || h1;
        if (is_hit) begin
            exp_meta.push_back({1'b0, mv[0][idx], h1, mt[0][idx]});
        end else begin
            vic = !mv[0][idx] ? 1'b0 : !mv[1][idx] ? 1'b1 : !ml[idx];
            for (int w = 0; w < 8; w++) begin
                wv = w[2:0];
                exp_addr.push_back({tag, idx, wv, 1'b0});
                exp_dw.push_back({vic, 8'(1 << w), data_of({tag, idx, wv, 1'b0})});
            end
            exp_meta.push_back({vic, 1'b1, 1'b0, tag});
            if (vic) exp_meta.push_back({1'b0, mv[0][idx], 1'b1, mt[0][idx]});
        end

        req = 1'b1;
        req_addr = addr;
        req_c = cyc;
        for (int n = 0; n < 300 && !fin; n++) begin
            @(negedge clk);
            if (meta_we0 && meta_we1) viol++;
            if (meta_we0) obs_meta.push_back({1'b0, meta_din});
            if (meta_we1) obs_meta.push_back({1'b1, meta_din});
            if (mem_en) begin
                obs_addr.push_back(mem_addr);
                lat = $urandom_range(lmax, lmin);
                due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
                last_due = due;
                pend.push_back('{due: due, data: data_of(mem_addr)});
            end
            if (data_we) begin
                obs_dw.push_back({data_way, data_word_en, data_wdata});
                last_dw = cyc;
            end
            if (done) begin
                ndone++;
                hit_obs = hit;
                done_c = cyc;
                fin = 1'b1;
            end
            if (abort_at > 0 && obs_dw.size() == abort_at) begin
                #2 rst = 1'b0;
                #1 check_idle_zero("rst_async");
                pend.delete();
                mem_valid = 1'b0;
                req = 1'b0;
                repeat (2) @(posedge clk);
                #1 check_idle_zero("rst_hold");
                rst = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            if (!fin) begin
                @(posedge clk);
                #1;
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    mem_valid = 1'b1;
                    mem_rdata = pend[0].data;
                    void'(pend.pop_front());
                end else begin
                    mem_valid = 1'b0;
                    mem_rdata = 16'($urandom);
                end
                req = busy ? 1'($urandom) : 1'b0;
                req_addr = 16'($urandom);
            end
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        mem_valid = 1'b0;

        check_eq("finished", 32'(fin), 1);
        check_eq("done_cnt", ndone, 1);
        check_eq("hit", 32'(hit_obs), 32'(is_hit));
        check_eq("we_excl", viol, 0);
        check_eq("meta_n", obs_meta.size(), exp_meta.size());
        for (int i = 0; i < obs_meta.size() && i < exp_meta.size(); i++)
            check_eq("meta_wr", 32'(obs_meta[i]), 32'(exp_meta[i]));
        check_eq("mem_n", obs_addr.size(), exp_addr.size());
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
            check_eq("mem_addr", 32'(obs_addr[i]), 32'(exp_addr[i]));
        check_eq("dwe_n", obs_dw.size(), exp_dw.size());
        for (int i = 0; i < obs_dw.size() && i < exp_dw.size(); i++)
            check_eq("data_wr", 32'(obs_dw[i]), 32'(exp_dw[i]));
        if (is_hit) check_eq("hit_lat", done_c - req_c, 2);
        else        check_eq("miss_tail", done_c - last_dw, vic ? 3 : 2);

        if (is_hit) begin
            ml[idx] = h1;
        end else begin
            mv[vic][idx] = 1'b1;
            mt[vic][idx] = tag;
            ml[idx] = vic;
        end
        check_eq("arr0", 32'(arr0[idx]), 32'({mv[0][idx], ml[idx], mt[0][idx]}));
        check_eq("arr1", 32'(arr1[idx]), 32'({mv[1][idx], 1'b0, mt[1][idx]}));
        check_idle_zero("idle");
    endtask

    initial begin
        logic [15:0] a;
        for (int i = 0; i < 64; i++) begin
            arr0[i] = 8'h00;
            arr1[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1 check_idle_zero("reset");
        rst = 1'b1;
        @(posedge clk);
        #1 check_idle_zero("post_reset");

        do_req(16'h1234, 1, 3, 0);
        check_eq("tp_way0_meta", 32'(arr0[6'h23]), 32'h84);
        do_req(16'h1234, 1, 3, 0);
        do_req(16'h5234, 2, 5, 0);
        check_eq("tp_way1_meta", 32'(arr1[6'h23]), 32'h94);
        check_eq("tp_lru_meta", 32'(arr0[6'h23]), 32'hC4);
        do_req(16'h1234, 1, 3, 0);
        do_req(16'h5234, 1, 1, 0);
        do_req(16'h9234, 4, 4, 0);
        check_eq("tp_way1_kept", 32'(arr1[6'h23]), 32'h94);

        do_req(16'hA7F0, 1, 4, 3);
        do_req(16'hA7F0, 1, 4, 0);

        for (int t = 0; t < 40; t++) begin
            a = 16'($urandom);
            a[15:10] = 6'($urandom_range(3, 0)) << 2;
            a[9:4]   = 6'h10 + 6'($urandom_range(2, 0));
            do_req(a, 1, 6, (t % 13 == 5) ? 1 + (t % 6) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
